// File: rtl/galaksija_pkg.sv
// Shared definitions for the Galaksija serial blocks: transmitter FSM encoding
// and framing constants.
package galaksija_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic [31:0] MIN_DIVIDER = 32'd2;

  // Dividers below 2 would give a zero- or one-cycle bit counter wrap; clamp them.
  function automatic logic [31:0] eff_divider(input logic [31:0] d);
    return (d < MIN_DIVIDER) ? MIN_DIVIDER : d;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock byte FIFO with first-word-fall-through read data.
module fifo_sync #(
  parameter int unsigned AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [7:0]  wdata,
  input  logic        rd,
  output logic [7:0]  rdata,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_LVL = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic          do_wr;
  logic          do_rd;

  // Full/empty come from the registered level, so a write while full is
  // dropped even if a pop happens on the same edge.
  assign full  = (level_q == DEPTH_LVL);
  assign empty = (level_q == '0);
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign level = level_q;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: FIFO-fed, LSB first, bit period latched per frame.
module uart_tx
  import galaksija_pkg::*;
#(
  parameter int unsigned FIFO_AW   = 3,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      cfg_divider,
  input  logic [7:0]       data,
  input  logic             valid,
  output logic             ready,
  output logic             ser_tx,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_level
);

  tx_state_t   state_q, state_d;
  logic [31:0] baud_q, baud_d;
  logic [31:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        pop;
  logic        load;
  logic        baud_end;
  logic [7:0]  head;
  logic        full;
  logic        empty;

  fifo_sync #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (valid),
    .wdata (data),
    .rd    (pop),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign ready    = ~full;
  assign busy     = (state_q != ST_IDLE) | ~empty;
  assign ser_tx   = tx_q;
  assign baud_end = (baud_q == div_q - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      div_q   <= MIN_DIVIDER;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty) load = 1'b1;
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 32'd1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 32'd1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next start bit when more data is queued.
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shift_d = head;
      div_d   = eff_divider(cfg_divider);
      baud_d  = '0;
      bit_d   = '0;
      state_d = ST_START;
      tx_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table, frame scoreboard, corner sequences.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg, cfg2;
  logic [7:0]  data, data2;
  logic        valid, valid2;
  logic        ready, ser_tx, busy;
  logic        ready2, ser_tx2, busy2;
  logic [3:0]  level, level2;

  always #5 clk = ~clk;

  uart_tx #(.FIFO_AW(3), .STOP_BITS(1)) dut (
    .clk         (clk),
    .reset       (rst),
    .cfg_divider (cfg),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .ser_tx      (ser_tx),
    .busy        (busy),
    .fifo_level  (level)
  );

  uart_tx #(.FIFO_AW(3), .STOP_BITS(2)) dut2 (
    .clk         (clk),
    .reset       (rst),
    .cfg_divider (cfg2),
    .data        (data2),
    .valid       (valid2),
    .ready       (ready2),
    .ser_tx      (ser_tx2),
    .busy        (busy2),
    .fifo_level  (level2)
  );

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  d;
    int unsigned div;
  } frame_t;

  typedef struct {
    logic [7:0]  d;
    logic [31:0] cfg;
    int unsigned exp_div;
  } vec_t;

  frame_t      sb[$];
  int unsigned starts[$];
  bit          mon_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr1(input logic [7:0] d);
    data  = d;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_busy_low(input string name, input int unsigned budget,
                               output int unsigned fall);
    int unsigned n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    fall = cyc;
    check({name, "_busy_timeout"}, busy, 0);
  endtask

  // Line monitor for dut: every cycle of every frame is compared against the
  // scoreboard entry popped at the start bit.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst && ser_tx === 1'b0) begin
        frame_t     e;
        logic [7:0] got;
        logic       expl;
        bit         bad;
        bit         abort;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got start bit expected idle line");
          e.d   = 8'h00;
          e.div = 4;
        end else begin
          e = sb.pop_front();
        end
        starts.push_back(cyc);
        bad   = 1'b0;
        abort = 1'b0;
        got   = '0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int c = 0; c < int'(e.div) && !abort; c++) begin
            if (b != 0 || c != 0) begin
              @(posedge clk);
              #1;
            end
            if (rst || !mon_en) begin
              abort = 1'b1;
            end else begin
              expl = (b == 0) ? 1'b0 : (b <= 8) ? e.d[b-1] : 1'b1;
              if (ser_tx !== expl) bad = 1'b1;
              if (b >= 1 && b <= 8 && c == int'(e.div / 2)) got[b-1] = ser_tx;
            end
          end
        end
        if (!abort) begin
          check("frame_timing", bad, 0);
          check("frame_data", got, e.d);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    int unsigned wn, fall, n;
    bit          resumed;
    int unsigned lows, highs, busy_k;
    logic [7:0]  got2;
    bit          seen_fall;

    vt = '{'{8'h55, 32'd4, 4}, '{8'h00, 32'd3, 3}, '{8'hFF, 32'd2, 2},
           '{8'hA5, 32'd0, 2}, '{8'h81, 32'd1, 2}, '{8'h3C, 32'd5, 5}};

    rst = 1'b1; valid = 1'b0; valid2 = 1'b0;
    cfg = 32'd4; cfg2 = 32'd217; data = '0; data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_tx", ser_tx, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single frames across dividers, including clamped 0 and 1.
    for (int i = 0; i < 6; i++) begin
      cfg = vt[i].cfg;
      sb.push_back('{vt[i].d, vt[i].exp_div});
      wr1(vt[i].d);
      wn = cyc;
      check("vec_level_after_write", level, 1);
      check("vec_line_before_start", ser_tx, 1);
      @(posedge clk);
      #1;
      check("vec_start_latency", ser_tx, 0);
      check("vec_level_after_pop", level, 0);
      check("vec_busy", busy, 1);
      wait_busy_low("vec", 200, fall);
      check("vec_busy_len", fall - wn, 10 * vt[i].exp_div + 1);
    end

    // Back-to-back frames with no idle gap between stop and next start.
    cfg = 32'd4;
    starts.delete();
    sb.push_back('{8'h7E, 4});
    wr1(8'h7E);
    check("b2b_level_a", level, 1);
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{8'h41, 4});
    wr1(8'h41);
    check("b2b_level_b", level, 1);
    sb.push_back('{8'h0D, 4});
    wr1(8'h0D);
    check("b2b_level_c", level, 2);
    n = 0;
    while (level != 4'd1 && n < 100) begin @(posedge clk); #1; n++; end
    check("b2b_level_d", level, 1);
    n = 0;
    while (level != 4'd0 && n < 100) begin @(posedge clk); #1; n++; end
    check("b2b_level_e", level, 0);
    wait_busy_low("b2b", 200, fall);
    check("b2b_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      check("b2b_gap1", starts[1] - starts[0], 40);
      check("b2b_gap2", starts[2] - starts[1], 40);
    end

    // FIFO full: one byte shifting plus eight queued; the tenth is dropped.
    cfg = 32'd1000;
    for (int i = 1; i <= 10; i++) begin
      check("full_ready_before_write", ready, (i <= 9) ? 1 : 0);
      if (i <= 9) sb.push_back('{8'h10 + 8'(i), (i == 1) ? 1000 : 4});
      wr1(8'h10 + 8'(i));
    end
    check("full_level", level, 8);
    check("full_ready", ready, 0);
    cfg = 32'd4;
    wait_busy_low("full", 12000, fall);
    check("full_sb_drained", sb.size(), 0);

    // Divider change mid-frame only affects the following frame.
    cfg = 32'd4;
    sb.push_back('{8'h96, 4});
    wr1(8'h96);
    repeat (5) @(posedge clk);
    #1;
    cfg = 32'd8;
    sb.push_back('{8'h69, 8});
    wr1(8'h69);
    wait_busy_low("divchg", 300, fall);
    check("divchg_sb_drained", sb.size(), 0);
    cfg = 32'd4;

    // Reset in the middle of a frame while more bytes are queued.
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{8'h00, 4});
      wr1(8'h00);
    end
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_line_low", ser_tx, 0);
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ser_tx", ser_tx, 1);
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_level", level, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    resumed = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (ser_tx !== 1'b1 || busy !== 1'b0) resumed = 1'b1;
    end
    check("midrst_no_resume", resumed, 0);
    mon_en = 1'b1;

    // Two stop bits at 217 cycles per bit, decoded from the line.
    data2  = 8'hFF;
    valid2 = 1'b1;
    @(posedge clk);
    #1;
    valid2 = 1'b0;
    lows = 0; highs = 0; busy_k = 0; got2 = '0; seen_fall = 1'b0;
    for (int k = 0; k < 2500 && !seen_fall; k++) begin
      @(posedge clk);
      #1;
      if (k < 217 && ser_tx2 === 1'b0) lows++;
      if (k >= 9 * 217 && k < 11 * 217 && ser_tx2 === 1'b1) highs++;
      for (int b = 1; b <= 8; b++)
        if (k == b * 217 + 108) got2[b-1] = ser_tx2;
      if (busy2 === 1'b0) begin
        busy_k = k;
        seen_fall = 1'b1;
      end
    end
    check("stop2_start_low_cycles", lows, 217);
    check("stop2_data", got2, 8'hFF);
    check("stop2_stop_high_cycles", highs, 434);
    check("stop2_frame_len", busy_k, 2387);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 serial transmitter; the transmit counterpart of the serial keyboard receiver (uart_rx).
- Used to send characters from the Galaksija core back to the host terminal, for example as an echo or as debug/printer output over ser_tx.
- Contains a small byte FIFO and accepts bytes through a valid/ready write port. It shifts each byte out LSB-first at the bit period set by cfg_divider.
- Runs in the CPU clock domain (clk, 25 MHz).

Parameters:
- FIFO_AW, 3, log2 of FIFO depth (default depth 8 bytes)
- STOP_BITS, 1, number of stop bits per frame (1 or 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_divider  in  32  bit period in clk cycles (f_clk/baud, e.g. 217 for 115200 baud)
- data  in  8  byte to transmit
- valid  in  1  write strobe; byte accepted on a rising edge where valid=1 and ready=1
- ready  out  1  FIFO not full
- ser_tx  out  1  serial line; idle high
- busy  out  1  frame in progress, or FIFO non-empty
- fifo_level  out  FIFO_AW+1  number of bytes queued, not counting the byte being shifted

Behaviour:
- Reset (asynchronous, active-high):
  - ser_tx=1, ready=1, busy=0, fifo_level=0.
  - FIFO pointers cleared; FSM goes to IDLE; baud counter and bit counter = 0.
  - Reset during a frame aborts it; the line returns high immediately and no partial frame resumes.
- All outputs are registered; ser_tx is driven straight from a flop, so it is glitch-free.
- FIFO:
  - Write when valid & ready; pop is requested by the FSM.
  - Simultaneous write and pop with level>0: level unchanged, both take effect.
  - Write while full (ready=0): byte dropped, level unchanged. This holds even if a pop occurs in the same cycle, because ready is based on the registered level.
  - Pointers wrap modulo 2^FIFO_AW; level saturates by construction at 2^FIFO_AW.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: ser_tx=1. When the FIFO is non-empty:
    - pop the head into the shift register;
    - latch the effective divider: div = cfg_divider, but values 0 and 1 are clamped to 2;
    - go to START and drive ser_tx=0 on the same edge.
  - START: hold for div cycles, then go to DATA with ser_tx=shift[0].
  - DATA: each bit lasts div cycles; shift right at each bit boundary. After the 8th bit has lasted div cycles, go to STOP with ser_tx=1.
  - STOP: hold for STOP_BITS*div cycles. At the end:
    - if the FIFO is non-empty, pop and go directly to START, so ser_tx=0 on that edge with no idle gap;
    - otherwise go to IDLE.
- Baud counter: counts 0..div-1 within each bit. Changes to cfg_divider mid-frame have no effect until the next frame.
- Timing:
  - Latency: a byte written at edge N into an empty FIFO while IDLE gives ser_tx falling at edge N+1.
  - Frame length = (1+8+STOP_BITS)*div clk cycles.
- busy: 1 from the pop edge until the edge where the FSM re-enters IDLE, and whenever level>0.

Decomposition:
- Shared package (galaksija_pkg):
  - FSM state encoding (2-bit enum IDLE/START/DATA/STOP);
  - constant DATA_BITS=8;
  - constant MIN_DIVIDER=2.
- Sub-module: fifo_sync.
  - Single-clock FIFO with parameter AW, 8-bit data.
  - Ports: clk, reset, wr, wdata, rd, rdata, level, full, empty.
  - Uses first-word-fall-through output, so the FSM can pop and load in the same edge.
- uart_tx holds only the FSM, the baud/bit counters and the shift register.

Test Plan:
- Reset values: with reset asserted mid-stream → ser_tx=1, ready=1, busy=0, fifo_level=0; with reset asserted mid-frame → line high within 0 cycles of assertion and no resumption after release.
- Single byte, cfg_divider=4, write 0x55 at edge N → ser_tx=0 from N+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop=1 for 4 cycles; busy falls at N+41.
- Back-to-back, cfg_divider=4, write 0x41,0x0D in consecutive cycles → second start bit begins exactly 40 cycles after the first, with no idle gap; fifo_level goes 1→2→1→0.
- FIFO full, FIFO_AW=3, hold the FSM in a long frame (cfg_divider=1000) and write 10 bytes → ready=0 after the 9th accepted byte (1 shifting + 8 queued); the 10th byte is dropped and is absent from the line.
- Divider edge cases: cfg_divider=0 → bit period 2 cycles; cfg_divider changed from 4 to 8 mid-frame → current frame keeps 4-cycle bits and the next frame uses 8.
- STOP_BITS=2 with cfg_divider=217 and byte 0xFF → frame lasts 11*217=2387 cycles, the stop level lasts 434 cycles, and the frame decodes correctly through the uart_rx instance in loopback.
